vga_timing_rx: RTL
==================

Name: vga_timing_rx

Overview:
- Receive side of the VGA timing interface. Consumes the hs/vs/blank stream produced by vga_controller and regenerates DrawX/DrawY from it.
- Measures line and frame periods, declares lock, and counts timing faults.
- Sits beside the display path as a self-check and debug block. err_count and locked are exported to LEDR/HEX through top-level glue.

Parameters:
- H_TOTAL, 800, pixels per line
- V_TOTAL, 525, lines per frame
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- H_SYNC_START, 656, DrawX of the first pixel with hs low
- V_SYNC_START, 490, DrawY of the first line with vs low

Ports:
- Clk  in  1  50 MHz system clock; all logic is on rising edge
- Reset  in  1  synchronous, active-high
- pix_ce  in  1  one-Clk pixel strobe (25 MHz rate); hs/vs/blank are sampled only when high
- hs  in  1  horizontal sync, active low
- vs  in  1  vertical sync, active low
- blank  in  1  blanking, active low (low = not visible)
- DrawX  out  10  recovered pixel column
- DrawY  out  10  recovered line
- active  out  1  DrawX<H_ACTIVE and DrawY<V_ACTIVE
- frame_start  out  1  one-Clk pulse on each vs falling edge
- locked  out  1  timing verified
- h_meas  out  10  last measured line period in pixels, saturating at 1023
- v_meas  out  10  last measured frame period in lines, saturating at 1023
- err_count  out  8  timing faults, saturating at 255

Behaviour:
- Reset values: every output 0; state SEARCH; previous-sample hs/vs registers 1.
- All updates occur only on Clk edges with pix_ce=1. Outputs are registered and change 1 Clk after the qualifying pix_ce.
- hs falling edge is a sample with hs=0 and previous hs=1. On it:
  - DrawX <= H_SYNC_START.
  - h_meas <= h_cnt+1; h_cnt <= 0.
- Otherwise DrawX increments. On reaching H_TOTAL-1 it wraps to 0 and DrawY increments.
- vs falling edge: DrawY <= V_SYNC_START; v_meas <= line count since the previous vs edge; frame_start pulses.
  - If hs and vs edges fall on the same sample, both apply. The vs assignment of DrawY wins over the wrap increment.
- DrawY wraps from V_TOTAL-1 to 0.
- h_cnt saturates at 1023.
- The first hs edge after Reset or after entering SEARCH establishes phase only; it is not checked against H_TOTAL.
- State machine:
  - SEARCH: on a vs falling edge, go to MEASURE and clear the line_bad flag.
  - MEASURE:
    - Any checked hs period not equal to H_TOTAL sets line_bad.
    - On the next vs falling edge: if line_bad=0 and v_meas=V_TOTAL, go to LOCKED and set locked=1. Otherwise stay in MEASURE and clear line_bad.
  - LOCKED: a fault increments err_count, drops locked, and goes to SEARCH. A fault is any of:
    - hs period not equal to H_TOTAL;
    - vs period not equal to V_TOTAL;
    - h_cnt reaching 1023 (line timeout).
- Multiple faults on the same sample count as one.
- Reset mid-frame restores the reset values; the lock procedure restarts.
- active is computed from the next DrawX/DrawY values and registered alongside them.

Optional Feature:
- Macro: VGA_RX_BLANK_CHECK_EN.
- Defined: while LOCKED, every sample with blank != active (blank=1 means visible) increments err_count once and returns to SEARCH. This catches blank/position skew in vga_controller.
- Undefined: the blank input is ignored and carries no logic.

Decomposition:
- Package vga_rx_pkg holds:
  - state enum {SEARCH, MEASURE, LOCKED};
  - default timing constants (800/525/640/480/656/490);
  - the 10-bit coordinate typedef.
- Sub-module vga_period_counter: a saturating period counter with edge-triggered capture, instantiated twice (pixels per line, lines per frame).

Test Plan:
- Reset asserted for 3 Clk mid-frame -> all outputs 0, locked=0 the Clk after release.
- Standard 800x525 stream from the vga_controller model ->
  - locked=0 after the first vs edge;
  - locked=1 exactly 1 Clk after the second vs edge;
  - h_meas=800, v_meas=525, err_count=0.
- Locked stream, compare at every pix_ce -> DrawX/DrawY equal the generator's counters (including (639,479) active=1 and (640,479) active=0); frame_start occurs once per 420000 pix_ce.
- Locked, one line shortened to 799 pixels -> h_meas=799, err_count=1, locked=0, state SEARCH; relocks 1 Clk after the second subsequent vs edge.
- Locked, hs held high -> err_count increments once when h_cnt reaches 1023; h_meas holds 800; locked=0.
- With VGA_RX_BLANK_CHECK_EN, blank forced high at DrawX=700 on one line -> err_count=1, locked=0. Without the macro, the same stimulus -> err_count=0, locked stays 1.

Source files
------------

// File: rtl/vga_timing_rx_pkg.sv
// vga_rx_pkg: shared types and default 640x480 timing constants for the VGA timing receiver
package vga_rx_pkg;
   typedef logic [9:0] coord_t;
   typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;
   localparam coord_t H_TOTAL_DEF      = 10'd800;
   localparam coord_t V_TOTAL_DEF      = 10'd525;
   localparam coord_t H_ACTIVE_DEF     = 10'd640;
   localparam coord_t V_ACTIVE_DEF     = 10'd480;
   localparam coord_t H_SYNC_START_DEF = 10'd656;
   localparam coord_t V_SYNC_START_DEF = 10'd490;
   localparam coord_t SAT_MAX          = 10'h3FF;
endpackage

// File: rtl/vga_timing_rx_if.sv
// vga_timing_rx_if: pixel-strobed hs/vs/blank stream from the VGA controller
interface vga_timing_rx_if;
   logic pix_ce;
   logic hs;
   logic vs;
   logic blank;
   modport master (output pix_ce, hs, vs, blank);
   modport slave  (input  pix_ce, hs, vs, blank);
endinterface

// File: rtl/vga_period_counter.sv
// vga_period_counter: saturating tick counter that reports the period ending at each capture edge
module vga_period_counter
   import vga_rx_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   ce,
   input  logic   tick,
   input  logic   capture,
   output coord_t meas,
   output coord_t period
);
   coord_t cnt;
   // period includes the tick of the capturing sample itself
   assign period = (tick && cnt != SAT_MAX) ? cnt + 10'd1 : cnt;
   // restart on each capture, otherwise accumulate up to saturation
   always_ff @(posedge clk)
      if (rst) begin
         cnt  <= '0;
         meas <= '0;
      end else if (ce) begin
         cnt  <= capture ? '0 : period;
         meas <= capture ? period : meas;
      end
endmodule

// File: rtl/vga_timing_rx.sv
// vga_timing_rx: regenerates DrawX/DrawY from hs/vs, measures periods, locks and counts faults (blank check under VGA_RX_BLANK_CHECK_EN)
module vga_timing_rx
   import vga_rx_pkg::*;
#(
   parameter coord_t H_TOTAL      = H_TOTAL_DEF,
   parameter coord_t V_TOTAL      = V_TOTAL_DEF,
   parameter coord_t H_ACTIVE     = H_ACTIVE_DEF,
   parameter coord_t V_ACTIVE     = V_ACTIVE_DEF,
   parameter coord_t H_SYNC_START = H_SYNC_START_DEF,
   parameter coord_t V_SYNC_START = V_SYNC_START_DEF
)(
   input  logic           Clk,
   input  logic           Reset,
   vga_timing_rx_if.slave rx,
   output coord_t         DrawX,
   output coord_t         DrawY,
   output logic           active,
   output logic           frame_start,
   output logic           locked,
   output coord_t         h_meas,
   output coord_t         v_meas,
   output logic [7:0]     err_count
);
   localparam coord_t X_LAST = H_TOTAL - 10'd1;
   localparam coord_t Y_LAST = V_TOTAL - 10'd1;
   state_t state, state_d;
   logic   hs_q, vs_q, h_armed, line_bad, line_bad_d, fault;
   logic   hs_fall, vs_fall, h_bad, v_bad, timeout, blank_bad;
   coord_t h_period, v_period, x_d, y_d;
   assign hs_fall = rx.pix_ce && !rx.hs && hs_q;
   assign vs_fall = rx.pix_ce && !rx.vs && vs_q;
   assign x_d = hs_fall ? H_SYNC_START : (DrawX == X_LAST) ? '0 : DrawX + 10'd1;
   assign y_d = vs_fall ? V_SYNC_START
              : (!hs_fall && DrawX == X_LAST) ? ((DrawY == Y_LAST) ? '0 : DrawY + 10'd1)
              : DrawY;
   assign h_bad   = hs_fall && h_armed && h_period != H_TOTAL;
   assign v_bad   = vs_fall && v_period != V_TOTAL;
   assign timeout = h_period == SAT_MAX;
`ifdef VGA_RX_BLANK_CHECK_EN
   assign blank_bad = rx.blank != (x_d < H_ACTIVE && y_d < V_ACTIVE);
`else
   assign blank_bad = 1'b0;
`endif
   assign locked = state == LOCKED;
   vga_period_counter u_line (
      .clk(Clk), .rst(Reset), .ce(rx.pix_ce), .tick(1'b1), .capture(hs_fall),
      .meas(h_meas), .period(h_period)
   );
   vga_period_counter u_frame (
      .clk(Clk), .rst(Reset), .ce(rx.pix_ce), .tick(hs_fall), .capture(vs_fall),
      .meas(v_meas), .period(v_period)
   );
   // lock procedure: qualify one whole frame, then watch for any timing fault
   always_comb begin
      state_d    = state;
      line_bad_d = line_bad;
      fault      = 1'b0;
      if (rx.pix_ce)
         case (state)
            SEARCH: if (vs_fall) begin
               state_d    = MEASURE;
               line_bad_d = 1'b0;
            end
            MEASURE: if (vs_fall) begin
               state_d    = (!line_bad && !h_bad && v_period == V_TOTAL) ? LOCKED : MEASURE;
               line_bad_d = 1'b0;
            end else
               line_bad_d = line_bad || h_bad;
            LOCKED: begin
               fault   = h_bad || v_bad || timeout || blank_bad;
               state_d = fault ? SEARCH : LOCKED;
            end
            default: state_d = SEARCH;
         endcase
   end
   // state register
   always_ff @(posedge Clk)
      if (Reset) begin
         state    <= SEARCH;
         line_bad <= 1'b0;
      end else begin
         state    <= state_d;
         line_bad <= line_bad_d;
      end
   // sync history, recovered position and fault counter
   always_ff @(posedge Clk)
      if (Reset) begin
         hs_q        <= 1'b1;
         vs_q        <= 1'b1;
         h_armed     <= 1'b0;
         DrawX       <= '0;
         DrawY       <= '0;
         active      <= 1'b0;
         frame_start <= 1'b0;
         err_count   <= '0;
      end else begin
         frame_start <= vs_fall;
         if (rx.pix_ce) begin
            hs_q      <= rx.hs;
            vs_q      <= rx.vs;
            h_armed   <= !fault && (h_armed || hs_fall);
            DrawX     <= x_d;
            DrawY     <= y_d;
            active    <= x_d < H_ACTIVE && y_d < V_ACTIVE;
            err_count <= err_count + 8'(fault && err_count != 8'hFF);
         end
      end
endmodule
